// File: rtl/instr_sequencer_pkg.sv
// state_definitions: shared constants and types for the instruction sequencer
// and the decode logic that consumes its one-hot state.
//   - STATE_1..STATE_24 : bit index of each micro-cycle in the one-hot vector
//   - LEN_*             : instruction lengths in micro-cycles
//   - OPC_* / PFX_*     : opcode match values and prefix masks
//   - ctrl_state_t      : control FSM encoding
package state_definitions;

    localparam int STATE_1  = 0;
    localparam int STATE_2  = 1;
    localparam int STATE_3  = 2;
    localparam int STATE_4  = 3;
    localparam int STATE_5  = 4;
    localparam int STATE_6  = 5;
    localparam int STATE_7  = 6;
    localparam int STATE_8  = 7;
    localparam int STATE_9  = 8;
    localparam int STATE_10 = 9;
    localparam int STATE_11 = 10;
    localparam int STATE_12 = 11;
    localparam int STATE_13 = 12;
    localparam int STATE_14 = 13;
    localparam int STATE_15 = 14;
    localparam int STATE_16 = 15;
    localparam int STATE_17 = 16;
    localparam int STATE_18 = 17;
    localparam int STATE_19 = 18;
    localparam int STATE_20 = 19;
    localparam int STATE_21 = 20;
    localparam int STATE_22 = 21;
    localparam int STATE_23 = 22;
    localparam int STATE_24 = 23;

    localparam int LEN_W = 5;

    localparam logic [LEN_W-1:0] LEN_8  = 5'd8;
    localparam logic [LEN_W-1:0] LEN_10 = 5'd10;
    localparam logic [LEN_W-1:0] LEN_12 = 5'd12;
    localparam logic [LEN_W-1:0] LEN_14 = 5'd14;
    localparam logic [LEN_W-1:0] LEN_24 = 5'd24;

    // Exact-match opcodes
    localparam logic [7:0] OPC_HALT  = 8'hAE;
    localparam logic [7:0] OPC_INCXY = 8'hB0;

    // Prefix masks and the values they are compared against
    localparam logic [7:0] PFX_MASK_2 = 8'hC0;
    localparam logic [7:0] PFX_MASK_4 = 8'hF0;
    localparam logic [7:0] PFX_MOV8   = 8'h00;
    localparam logic [7:0] PFX_SETAB  = 8'h40;
    localparam logic [7:0] PFX_ALU    = 8'h80;
    localparam logic [7:0] PFX_LDST   = 8'h90;
    localparam logic [7:0] PFX_MOV16  = 8'hA0;
    localparam logic [7:0] PFX_MISC   = 8'hB0;
    localparam logic [7:0] PFX_GOTO   = 8'hC0;

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_RUN  = 2'd1,
        CTRL_STEP = 2'd2,
        CTRL_HALT = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/inst_length_decode.sv
// inst_length_decode: combinational map from the instruction register to the
// instruction length in micro-cycles and a HALT flag.
//   inst_reg_value : in  8  instruction register contents
//   length         : out 5  micro-cycle count (8, 10, 12, 14 or 24)
//   is_halt        : out 1  instruction is HALT
import state_definitions::*;

module inst_length_decode (
    input  logic [7:0]       inst_reg_value,
    output logic [LEN_W-1:0] length,
    output logic             is_halt
);

    // First match wins: HALT (8'hAE) sits inside the MOV-16 prefix and INCXY
    // sits inside the NOP prefix, so the exact matches are tested first.
    always_comb begin
        length  = LEN_8;
        is_halt = 1'b0;
        if (inst_reg_value == OPC_HALT) begin
            length  = LEN_10;
            is_halt = 1'b1;
        end else if ((inst_reg_value & PFX_MASK_2) == PFX_MOV8) begin
            length = LEN_8;
        end else if ((inst_reg_value & PFX_MASK_2) == PFX_SETAB) begin
            length = LEN_8;
        end else if ((inst_reg_value & PFX_MASK_4) == PFX_ALU) begin
            length = LEN_8;
        end else if ((inst_reg_value & PFX_MASK_4) == PFX_LDST) begin
            length = LEN_12;
        end else if ((inst_reg_value & PFX_MASK_4) == PFX_MOV16) begin
            length = LEN_10;
        end else if (inst_reg_value == OPC_INCXY) begin
            length = LEN_14;
        end else if ((inst_reg_value & PFX_MASK_4) == PFX_MISC) begin
            length = LEN_8;
        end else if ((inst_reg_value & PFX_MASK_2) == PFX_GOTO) begin
            length = LEN_24;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: one-hot micro-cycle sequencer with run / single-step / HALT
// control for the relay-computer core.
//   clk            : in  1   clock
//   reset_n        : in  1   synchronous active-low reset
//   run_en         : in  1   run continuously while high
//   step_req       : in  1   pulse: execute one instruction from IDLE
//   inst_reg_value : in  8   instruction register
//   fsm_state      : out 24  one-hot micro-cycle, all-zero when not executing
//   instr_done     : out 1   high during the final micro-cycle
//   halted         : out 1   high while in HALT
//   instr_count    : out 16  completed-instruction count (wraps)
import state_definitions::*;

module instr_sequencer #(
    parameter int N_STATES = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run_en,
    input  logic                step_req,
    input  logic [7:0]          inst_reg_value,
    output logic [N_STATES-1:0] fsm_state,
    output logic                instr_done,
    output logic                halted,
    output logic [15:0]         instr_count
);

    localparam logic [N_STATES-1:0] FIRST_STATE = {{(N_STATES-1){1'b0}}, 1'b1};

    ctrl_state_t      ctrl;
    logic [LEN_W-1:0] dec_len;
    logic             dec_halt;
    logic [LEN_W-1:0] len_q;
    logic             halt_q;
    logic             at_final;

    inst_length_decode u_decode (
        .inst_reg_value (inst_reg_value),
        .length         (dec_len),
        .is_halt        (dec_halt)
    );

    // All lengths are >= 8, so while in state_1..state_3 a stale length from
    // the previous instruction can never point at the active bit.
    assign at_final = fsm_state[len_q - 5'd1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl        <= CTRL_IDLE;
            fsm_state   <= '0;
            instr_done  <= 1'b0;
            halted      <= 1'b0;
            instr_count <= '0;
            len_q       <= LEN_8;
            halt_q      <= 1'b0;
        end else begin
            case (ctrl)
                CTRL_IDLE: begin
                    instr_done <= 1'b0;
                    halted     <= 1'b0;
                    if (run_en) begin
                        ctrl      <= CTRL_RUN;
                        fsm_state <= FIRST_STATE;
                    end else if (step_req) begin
                        ctrl      <= CTRL_STEP;
                        fsm_state <= FIRST_STATE;
                    end
                end

                CTRL_RUN, CTRL_STEP: begin
                    if (at_final) begin
                        instr_done  <= 1'b0;
                        instr_count <= instr_count + 16'd1;
                        if (halt_q) begin
                            ctrl      <= CTRL_HALT;
                            fsm_state <= '0;
                            halted    <= 1'b1;
                        end else if (ctrl == CTRL_STEP || !run_en) begin
                            ctrl      <= CTRL_IDLE;
                            fsm_state <= '0;
                        end else begin
                            fsm_state <= FIRST_STATE;
                        end
                    end else begin
                        fsm_state  <= fsm_state << 1;
                        // Registered: goes high as the vector enters state_L.
                        instr_done <= fsm_state[len_q - 5'd2];
                        // IR is loaded in state_2 and stable by state_3.
                        if (fsm_state[STATE_3]) begin
                            len_q  <= dec_len;
                            halt_q <= dec_halt;
                        end
                    end
                end

                CTRL_HALT: begin
                    fsm_state  <= '0;
                    instr_done <= 1'b0;
                    halted     <= 1'b1;
                    // Operator must drop run_en before the core can restart.
                    if (!run_en) begin
                        ctrl   <= CTRL_IDLE;
                        halted <= 1'b0;
                    end
                end

                default: begin
                    ctrl      <= CTRL_IDLE;
                    fsm_state <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run_en;
    logic        step_req;
    logic [7:0]  inst_reg_value;
    logic [23:0] fsm_state;
    logic        instr_done;
    logic        halted;
    logic [15:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;

    instr_sequencer #(.N_STATES(24)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .run_en         (run_en),
        .step_req       (step_req),
        .inst_reg_value (inst_reg_value),
        .fsm_state      (fsm_state),
        .instr_done     (instr_done),
        .halted         (halted),
        .instr_count    (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic [7:0]  ir;
        logic [23:0] fsm;
        logic        done;
        logic        halt;
        logic [15:0] cnt;
    } vec_t;

    vec_t        vec [128];
    int          n_vec = 0;
    logic [15:0] mcnt  = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge; the one-hot invariant
    // is checked on every sampled cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        check("onehot0", {31'd0, $onehot0(fsm_state)}, 32'd1);
    endtask

    task automatic add(input logic r, input logic [7:0] ir, input logic [23:0] f,
                       input logic d, input logic h, input logic [15:0] c);
        vec[n_vec].run  = r;
        vec[n_vec].ir   = ir;
        vec[n_vec].fsm  = f;
        vec[n_vec].done = d;
        vec[n_vec].halt = h;
        vec[n_vec].cnt  = c;
        n_vec++;
    endtask

    // One instruction of len cycles; vector i expects state_(i+1). The run
    // level in vector i is sampled on the edge that produces that state.
    // drop_at > 0 lowers run_en from vector drop_at onwards.
    task automatic add_instr(input logic [7:0] ir, input int len, input int drop_at);
        for (int i = 0; i < len; i++) begin
            add((drop_at == 0) || (i < drop_at), ir, 24'd1 << i,
                i == len - 1, 1'b0, mcnt);
        end
        mcnt = mcnt + 16'd1;
    endtask

    initial begin
        int dones;

        reset_n        = 1'b0;
        run_en         = 1'b0;
        step_req       = 1'b0;
        inst_reg_value = 8'h00;

        // Table: MOV-8, LOAD, INCXY, GOTO, HALT, restart, MOV-8 with run dropped
        add_instr(8'h00, 8, 0);
        add_instr(8'h90, 12, 0);
        add_instr(8'hB0, 14, 0);
        add_instr(8'hC0, 24, 0);
        add_instr(8'hAE, 10, 0);
        add(1'b1, 8'hAE, 24'h0, 1'b0, 1'b1, 16'd5);
        add(1'b1, 8'hAE, 24'h0, 1'b0, 1'b1, 16'd5);
        add(1'b0, 8'hAE, 24'h0, 1'b0, 1'b0, 16'd5);
        add_instr(8'h00, 8, 3);
        add(1'b0, 8'h00, 24'h0, 1'b0, 1'b0, 16'd6);

        // Reset state
        tick();
        tick();
        check("rst_fsm", {8'd0, fsm_state}, 32'd0);
        check("rst_done", {31'd0, instr_done}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_count", {16'd0, instr_count}, 32'd0);
        reset_n = 1'b1;
        tick();
        check("idle_fsm", {8'd0, fsm_state}, 32'd0);

        for (int k = 0; k < n_vec; k++) begin
            run_en         = vec[k].run;
            inst_reg_value = vec[k].ir;
            tick();
            check($sformatf("vec%0d_fsm", k), {8'd0, fsm_state}, {8'd0, vec[k].fsm});
            check($sformatf("vec%0d_done", k), {31'd0, instr_done}, {31'd0, vec[k].done});
            check($sformatf("vec%0d_halted", k), {31'd0, halted}, {31'd0, vec[k].halt});
            check($sformatf("vec%0d_count", k), {16'd0, instr_count}, {16'd0, vec[k].cnt});
        end

        // Single step of MOV-16; a second step_req mid-instruction is ignored
        run_en         = 1'b0;
        inst_reg_value = 8'hA0;
        step_req       = 1'b1;
        tick();
        step_req = 1'b0;
        check("step_s1", {8'd0, fsm_state}, 32'h1);
        dones = 0;
        for (int i = 1; i < 10; i++) begin
            step_req = (i == 3);
            tick();
            check($sformatf("step_s%0d", i + 1), {8'd0, fsm_state}, 32'd1 << i);
            if (instr_done) dones++;
        end
        step_req = 1'b0;
        check("step_done_pulses", dones, 1);
        tick();
        check("step_end_fsm", {8'd0, fsm_state}, 32'd0);
        check("step_end_count", {16'd0, instr_count}, 32'd7);
        check("step_end_done", {31'd0, instr_done}, 32'd0);
        tick();
        check("step_stays_idle", {8'd0, fsm_state}, 32'd0);

        // GOTO with run_en dropped in state_5 and IR changed in state_6
        run_en         = 1'b1;
        inst_reg_value = 8'hC0;
        tick();
        check("drop_s1", {8'd0, fsm_state}, 32'h1);
        for (int i = 1; i < 24; i++) begin
            if (i == 5) run_en = 1'b0;
            if (i == 6) inst_reg_value = 8'h00;
            tick();
            check($sformatf("drop_s%0d", i + 1), {8'd0, fsm_state}, 32'd1 << i);
            check($sformatf("drop_done%0d", i + 1), {31'd0, instr_done}, {31'd0, (i == 23)});
        end
        tick();
        check("drop_end_fsm", {8'd0, fsm_state}, 32'd0);
        check("drop_end_count", {16'd0, instr_count}, 32'd8);
        check("drop_end_halted", {31'd0, halted}, 32'd0);

        // Counter wrap: preload FFFF while idle, then complete one instruction
        force dut.instr_count = 16'hFFFF;
        #1;
        release dut.instr_count;
        inst_reg_value = 8'h00;
        step_req       = 1'b1;
        tick();
        step_req = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        check("wrap_pre", {16'd0, instr_count}, 32'h0000FFFF);
        tick();
        check("wrap_post", {16'd0, instr_count}, 32'd0);
        check("wrap_idle", {8'd0, fsm_state}, 32'd0);

        // Reset in state_7 of a running instruction
        run_en = 1'b1;
        tick();
        for (int i = 1; i < 7; i++) tick();
        check("mid_s7", {8'd0, fsm_state}, 32'h40);
        reset_n = 1'b0;
        tick();
        check("mid_rst_fsm", {8'd0, fsm_state}, 32'd0);
        check("mid_rst_done", {31'd0, instr_done}, 32'd0);
        check("mid_rst_halted", {31'd0, halted}, 32'd0);
        check("mid_rst_count", {16'd0, instr_count}, 32'd0);
        reset_n = 1'b1;
        tick();
        check("post_rst_start", {8'd0, fsm_state}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
